// File: rtl/key_pkg.sv
// Shared types and constants for the push-button conditioning path.
package key_pkg;

    typedef enum logic [1:0] {
        KEY_RELEASED    = 2'd0,
        KEY_PRESS_CHK   = 2'd1,
        KEY_PRESSED     = 2'd2,
        KEY_RELEASE_CHK = 2'd3
    } key_state_e;

    localparam int unsigned DEBOUNCE_20MS_AT_10MHZ = 200000;
    localparam int unsigned SIM_DEBOUNCE           = 4;

endpackage

// File: rtl/key_debounce_if.sv
// Board-side view of a debounced key: raw pad in, conditioned level and pulses out.
interface key_debounce_if;

    logic key_in;
    logic key_level;
    logic key_down;
    logic key_up;
    logic key_busy;

    modport master (
        output key_in,
        input  key_level, key_down, key_up, key_busy
    );

    modport slave (
        input  key_in,
        output key_level, key_down, key_up, key_busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs; resets to RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronized pad, qualification FSM, registered level and
// single-cycle press/release pulses.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS_AT_10MHZ,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clk_in,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_down,
    output logic key_up,
    output logic key_busy
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic key_sync;
    logic k_s;

    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             down_q;
    logic             up_q;
    logic             busy_q;

    // Released pad level equals KEY_ACTIVE_LOW, so the flops reset to it.
    sync_2ff #(
        .RST_VAL (KEY_ACTIVE_LOW)
    ) u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (key_in),
        .q      (key_sync)
    );

    assign k_s = key_sync ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q <= KEY_RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            down_q  <= 1'b0;
            up_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            down_q <= 1'b0;
            up_q   <= 1'b0;
            case (state_q)
                KEY_RELEASED: begin
                    if (k_s) begin
                        state_q <= KEY_PRESS_CHK;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                KEY_PRESS_CHK: begin
                    if (!k_s) begin
                        state_q <= KEY_RELEASED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= KEY_PRESSED;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        down_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                KEY_PRESSED: begin
                    if (!k_s) begin
                        state_q <= KEY_RELEASE_CHK;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                KEY_RELEASE_CHK: begin
                    if (k_s) begin
                        state_q <= KEY_PRESSED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= KEY_RELEASED;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        up_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= KEY_RELEASED;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign key_level = level_q;
    assign key_down  = down_q;
    assign key_up    = up_q;
    assign key_busy  = busy_q;

endmodule
